// File: rtl/dm_sba_pkg.sv
// Shared types and helpers for the debug-module system-bus access engine.
package dm_sba_pkg;

  typedef enum logic [2:0] {
    SBA_IDLE,
    SBA_RD_REQ,
    SBA_RD_WAIT,
    SBA_WR_REQ,
    SBA_WR_WAIT
  } sba_state_e;

  typedef enum logic [2:0] {
    SBERR_NONE     = 3'd0,
    SBERR_TIMEOUT  = 3'd1,
    SBERR_BADALIGN = 3'd3,
    SBERR_BADSIZE  = 3'd4
  } sberr_e;

  // Byte-lane mask for a 2^size-byte access starting at byte offset, clipped to the bus.
  function automatic logic [7:0] sba_be(input logic [2:0] size, input logic [2:0] offset,
                                        input int unsigned bus_width);
    logic [15:0] ones;
    logic [15:0] lanes;
    ones  = (16'd1 << (16'd1 << size)) - 16'd1;
    lanes = (16'd1 << (bus_width / 8)) - 16'd1;
    return 8'((ones << offset) & lanes);
  endfunction

endpackage

// File: rtl/dm_sba_burst_if.sv
// Host-side request/response port of the SBA engine; master drives req, slave answers gnt/r_valid.
interface dm_sba_burst_if #(
  parameter int unsigned BusWidth = 32
);
  logic                    req;
  logic [BusWidth-1:0]     add;
  logic                    we;
  logic [BusWidth-1:0]     wdata;
  logic [BusWidth/8-1:0]   be;
  logic                    gnt;
  logic                    r_valid;
  logic [BusWidth-1:0]     r_rdata;

  modport master (output req, add, we, wdata, be, input gnt, r_valid, r_rdata);
  modport slave  (input req, add, we, wdata, be, output gnt, r_valid, r_rdata);
endinterface

// File: rtl/dm_sba_timeout.sv
// Per-phase watchdog: reloads on load_i, counts while en_i, flags expiry after TimeoutCycles
// enabled cycles. TimeoutCycles == 0 never expires.
module dm_sba_timeout #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] LoadVal = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (TimeoutCycles != 0) && en_i && (cnt_q == '0);
endmodule

// File: rtl/dm_sba_burst.sv
// SBA engine: CSR triggers become single writes or autoincrementing read bursts on the host port.
// Trigger->req 1 cycle, r_valid->sbdata_valid 1 cycle; req held until gnt, phases bounded by timeout.
module dm_sba_burst
  import dm_sba_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned MaxBurst      = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           dmactive_i,
  input  logic [BusWidth-1:0]            sbaddress_i,
  input  logic                           sbaddress_write_valid_i,
  output logic [BusWidth-1:0]            sbaddress_o,
  input  logic [2:0]                     sbaccess_i,
  input  logic                           sbreadonaddr_i,
  input  logic                           sbreadondata_i,
  input  logic                           sbautoincrement_i,
  input  logic [$clog2(MaxBurst+1)-1:0]  sbburstlen_i,
  input  logic [BusWidth-1:0]            sbdata_i,
  input  logic                           sbdata_write_valid_i,
  input  logic                           sbdata_read_valid_i,
  output logic [BusWidth-1:0]            sbdata_o,
  output logic                           sbdata_valid_o,
  output logic                           sbbusy_o,
  output logic                           sbbusyerror_o,
  output logic                           sberror_valid_o,
  output logic [2:0]                     sberror_o,
  dm_sba_burst_if.master                 host
);
  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned BlW      = $clog2(MaxBurst + 1);

  sba_state_e          state_d, state_q;
  logic [BusWidth-1:0] addr_d, addr_q;
  logic [2:0]          size_d, size_q;
  logic [BusWidth-1:0] wdata_d, wdata_q;
  logic [BlW-1:0]      beats_d, beats_q;
  logic [BusWidth-1:0] rdata_d, rdata_q;
  logic                rvld_d, rvld_q;
  logic                busyerr_d, busyerr_q;
  logic                err_vld_d, err_vld_q;
  sberr_e              err_d, err_q;

  logic                trig_wr, trig_rd, any_strobe;
  logic                bad_size, bad_align, expired, req;
  logic [BlW-1:0]      burst_len;
  logic [BusWidth-1:0] eff_addr, align_mask, wdata_rep, addr_inc;
  logic [BusWidth-1:0] rd_shift, rd_mask, rd_beat;
  logic [7:0]          be_full;

  assign trig_wr    = sbdata_write_valid_i;
  assign trig_rd    = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                      (sbdata_read_valid_i && sbreadondata_i);
  assign any_strobe = sbaddress_write_valid_i || sbdata_write_valid_i || sbdata_read_valid_i;

  // A readonaddr trigger must check and use the address being written this cycle.
  assign eff_addr   = sbaddress_write_valid_i ? sbaddress_i : addr_q;
  assign bad_size   = (32'd8 << sbaccess_i) > BusWidth;
  assign align_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
  assign bad_align  = (eff_addr & align_mask) != '0;
  assign addr_inc   = addr_q + (BusWidth'(1) << size_q);

  always_comb begin
    burst_len = sbburstlen_i;
    if (sbburstlen_i == '0)                burst_len = BlW'(1);
    else if (sbburstlen_i > BlW'(MaxBurst)) burst_len = BlW'(MaxBurst);
  end

  always_comb begin
    wdata_rep = '0;
    for (int i = 0; i < NumBytes; i++) begin
      wdata_rep[8*i +: 8] = sbdata_i[8*(i & ((1 << sbaccess_i) - 1)) +: 8];
    end
  end

  assign rd_shift = host.r_rdata >> {addr_q[OffW-1:0], 3'b000};
  assign rd_mask  = ((32'd8 << size_q) >= BusWidth) ? '1
                  : (BusWidth'(1) << (32'd8 << size_q)) - BusWidth'(1);
  assign rd_beat  = rd_shift & rd_mask;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    beats_d   = beats_q;
    rdata_d   = rdata_q;
    rvld_d    = 1'b0;
    busyerr_d = 1'b0;
    err_vld_d = 1'b0;
    err_d     = SBERR_NONE;

    case (state_q)
      SBA_IDLE: begin
        if (sbaddress_write_valid_i) addr_d = sbaddress_i;
        if (trig_wr || trig_rd) begin
          if (bad_size) begin
            err_vld_d = 1'b1;
            err_d     = SBERR_BADSIZE;
          end else if (bad_align) begin
            err_vld_d = 1'b1;
            err_d     = SBERR_BADALIGN;
          end else if (trig_wr) begin
            state_d = SBA_WR_REQ;
            size_d  = sbaccess_i;
            wdata_d = wdata_rep;
            beats_d = '0;
          end else begin
            state_d = SBA_RD_REQ;
            size_d  = sbaccess_i;
            beats_d = burst_len;
          end
        end
      end
      SBA_RD_REQ, SBA_WR_REQ: begin
        if (host.gnt) begin
          state_d = (state_q == SBA_RD_REQ) ? SBA_RD_WAIT : SBA_WR_WAIT;
        end else if (expired) begin
          state_d   = SBA_IDLE;
          beats_d   = '0;
          err_vld_d = 1'b1;
          err_d     = SBERR_TIMEOUT;
        end
      end
      SBA_RD_WAIT, SBA_WR_WAIT: begin
        if (host.r_valid) begin
          if (sbautoincrement_i) addr_d = addr_inc;
          if (state_q == SBA_RD_WAIT) begin
            rdata_d = rd_beat;
            rvld_d  = 1'b1;
            beats_d = beats_q - BlW'(1);
            state_d = (beats_q > BlW'(1)) ? SBA_RD_REQ : SBA_IDLE;
          end else begin
            state_d = SBA_IDLE;
          end
        end else if (expired) begin
          state_d   = SBA_IDLE;
          beats_d   = '0;
          err_vld_d = 1'b1;
          err_d     = SBERR_TIMEOUT;
        end
      end
      default: state_d = SBA_IDLE;
    endcase

    if ((state_q != SBA_IDLE) && any_strobe) busyerr_d = 1'b1;

    // Deactivation is a silent abort: no error, no data, address forgotten.
    if (!dmactive_i) begin
      state_d   = SBA_IDLE;
      addr_d    = '0;
      beats_d   = '0;
      rvld_d    = 1'b0;
      busyerr_d = 1'b0;
      err_vld_d = 1'b0;
      err_d     = SBERR_NONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SBA_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      beats_q   <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      busyerr_q <= 1'b0;
      err_vld_q <= 1'b0;
      err_q     <= SBERR_NONE;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      beats_q   <= beats_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
      busyerr_q <= busyerr_d;
      err_vld_q <= err_vld_d;
      err_q     <= err_d;
    end
  end

  dm_sba_timeout #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (state_d != state_q),
    .en_i      (state_q != SBA_IDLE),
    .expired_o (expired)
  );

  assign req        = (state_q == SBA_RD_REQ) || (state_q == SBA_WR_REQ);
  assign be_full    = sba_be(size_q, 3'(addr_q[OffW-1:0]), BusWidth);
  assign host.req   = req;
  assign host.we    = (state_q == SBA_WR_REQ);
  assign host.add   = req ? {addr_q[BusWidth-1:OffW], {OffW{1'b0}}} : '0;
  assign host.wdata = (state_q == SBA_WR_REQ) ? wdata_q : '0;
  assign host.be    = req ? be_full[NumBytes-1:0] : '0;

  assign sbaddress_o     = addr_q;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = rvld_q;
  assign sbbusy_o        = (state_q != SBA_IDLE);
  assign sbbusyerror_o   = busyerr_q;
  assign sberror_valid_o = err_vld_q;
  assign sberror_o       = err_q;
endmodule

// File: tb/tb_dm_sba_burst.sv
// Directed bench for dm_sba_burst on a 32-bit bus with a 16-cycle watchdog.
module tb_dm_sba_burst;
  localparam int unsigned BW = 32;

  logic          clk = 1'b0;
  logic          rst, dmactive;
  logic [BW-1:0] sbaddress_i, sbaddress_o, sbdata_i, sbdata_o;
  logic          sbaddress_wv, sbdata_wv, sbdata_rv;
  logic [2:0]    sbaccess, sberror;
  logic          readonaddr, readondata, autoinc;
  logic [3:0]    burstlen;
  logic          sbdata_valid, sbbusy, sbbusyerror, sberror_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_sba_burst_if #(.BusWidth(BW)) host ();

  dm_sba_burst #(
    .BusWidth(BW), .MaxBurst(8), .TimeoutCycles(16)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .dmactive_i              (dmactive),
    .sbaddress_i             (sbaddress_i),
    .sbaddress_write_valid_i (sbaddress_wv),
    .sbaddress_o             (sbaddress_o),
    .sbaccess_i              (sbaccess),
    .sbreadonaddr_i          (readonaddr),
    .sbreadondata_i          (readondata),
    .sbautoincrement_i       (autoinc),
    .sbburstlen_i            (burstlen),
    .sbdata_i                (sbdata_i),
    .sbdata_write_valid_i    (sbdata_wv),
    .sbdata_read_valid_i     (sbdata_rv),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid),
    .sbbusy_o                (sbbusy),
    .sbbusyerror_o           (sbbusyerror),
    .sberror_valid_o         (sberror_valid),
    .sberror_o               (sberror),
    .host                    (host)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dmactive = 1'b1;
    sbaddress_i = '0; sbaddress_wv = 1'b0; sbdata_i = '0; sbdata_wv = 1'b0; sbdata_rv = 1'b0;
    sbaccess = 3'd2; readonaddr = 1'b0; readondata = 1'b0; autoinc = 1'b0; burstlen = 4'd1;
    host.gnt = 1'b0; host.r_valid = 1'b0; host.r_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", host.req, 0);
    chk("rst_busy", sbbusy, 0);
    chk("rst_addr", sbaddress_o, 0);
    chk("rst_errvld", sberror_valid, 0);
    chk("rst_dvld", sbdata_valid, 0);

    // 32-bit write
    sbaddress_i = 32'h1000_0004; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    chk("wr_addr_load", sbaddress_o, 32'h1000_0004);
    sbdata_i = 32'hDEAD_BEEF; sbdata_wv = 1'b1; host.gnt = 1'b1; tick(); sbdata_wv = 1'b0;
    chk("wr_req", host.req, 1);
    chk("wr_add", host.add, 32'h1000_0004);
    chk("wr_be", host.be, 4'b1111);
    chk("wr_we", host.we, 1);
    chk("wr_wdata", host.wdata, 32'hDEAD_BEEF);
    chk("wr_busy1", sbbusy, 1);
    tick();
    chk("wr_busy2", sbbusy, 1);
    chk("wr_wait_req", host.req, 0);
    host.r_valid = 1'b1; tick(); host.r_valid = 1'b0;
    chk("wr_done_busy", sbbusy, 0);
    chk("wr_no_dvld", sbdata_valid, 0);

    // byte read at offset 3, burst length 0 behaves as 1
    sbaccess = 3'd0; burstlen = 4'd0; readonaddr = 1'b1;
    sbaddress_i = 32'h1000_0003; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    chk("rb_req", host.req, 1);
    chk("rb_add", host.add, 32'h1000_0000);
    chk("rb_be", host.be, 4'b1000);
    chk("rb_we", host.we, 0);
    tick();
    host.r_valid = 1'b1; host.r_rdata = 32'hAABB_CCDD; tick(); host.r_valid = 1'b0;
    chk("rb_dvld", sbdata_valid, 1);
    chk("rb_data", sbdata_o, 32'h0000_00AA);
    chk("rb_single_beat", sbbusy, 0);
    tick();
    chk("rb_dvld_pulse", sbdata_valid, 0);

    // 4-beat word burst with autoincrement
    sbaccess = 3'd2; burstlen = 4'd4; autoinc = 1'b1;
    sbaddress_i = 32'h0000_2000; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bu_req", host.req, 1);
      chk("bu_add", host.add, 32'h2000 + 4 * i);
      tick();
      host.r_valid = 1'b1; host.r_rdata = 32'hC0DE_0000 + i; tick(); host.r_valid = 1'b0;
      chk("bu_dvld", sbdata_valid, 1);
      chk("bu_data", sbdata_o, 32'hC0DE_0000 + i);
    end
    chk("bu_idle", sbbusy, 0);
    chk("bu_final_addr", sbaddress_o, 32'h0000_2010);
    autoinc = 1'b0; burstlen = 4'd1;
    tick();

    // misaligned halfword, then unsupported 64-bit access
    sbaccess = 3'd1; sbaddress_i = 32'h1; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    chk("al_errvld", sberror_valid, 1);
    chk("al_code", sberror, 3);
    chk("al_noreq", host.req, 0);
    chk("al_busy", sbbusy, 0);
    tick();
    chk("al_pulse", sberror_valid, 0);
    sbaccess = 3'd3; sbaddress_i = 32'h8; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    chk("sz_errvld", sberror_valid, 1);
    chk("sz_code", sberror, 4);
    chk("sz_noreq", host.req, 0);
    readonaddr = 1'b0;
    tick();

    // grant withheld: 16 cycles in RD_REQ, then timeout
    sbaccess = 3'd2; readondata = 1'b1; host.gnt = 1'b0;
    sbdata_rv = 1'b1; tick(); sbdata_rv = 1'b0;
    chk("to_req_start", host.req, 1);
    repeat (15) tick();
    chk("to_req_last", host.req, 1);
    chk("to_no_err_yet", sberror_valid, 0);
    tick();
    chk("to_req_drop", host.req, 0);
    chk("to_errvld", sberror_valid, 1);
    chk("to_code", sberror, 1);
    chk("to_busy", sbbusy, 0);
    host.r_valid = 1'b1; host.r_rdata = 32'h1234; tick(); host.r_valid = 1'b0;
    chk("to_late_rvalid", sbdata_valid, 0);

    // write strobe while waiting for a read response
    host.gnt = 1'b1; sbdata_rv = 1'b1; tick(); sbdata_rv = 1'b0;
    tick();
    chk("be_wait_busy", sbbusy, 1);
    sbdata_i = 32'hFFFF_FFFF; sbdata_wv = 1'b1; tick(); sbdata_wv = 1'b0;
    chk("be_busyerr", sbbusyerror, 1);
    chk("be_no_wr_req", host.req, 0);
    host.r_valid = 1'b1; host.r_rdata = 32'h55; tick(); host.r_valid = 1'b0;
    chk("be_dvld", sbdata_valid, 1);
    chk("be_data", sbdata_o, 32'h55);
    chk("be_busyerr_pulse", sbbusyerror, 0);

    // dmactive drop aborts silently and clears the address
    sbdata_rv = 1'b1; host.gnt = 1'b0; tick(); sbdata_rv = 1'b0;
    chk("da_req", host.req, 1);
    dmactive = 1'b0; tick();
    chk("da_req_drop", host.req, 0);
    chk("da_busy", sbbusy, 0);
    chk("da_addr", sbaddress_o, 0);
    chk("da_noerr", sberror_valid, 0);
    dmactive = 1'b1;

    // reset in the middle of a burst
    sbaddress_i = 32'h40; sbaddress_wv = 1'b1; tick(); sbaddress_wv = 1'b0;
    burstlen = 4'd4; autoinc = 1'b1; host.gnt = 1'b1;
    sbdata_rv = 1'b1; tick(); sbdata_rv = 1'b0;
    tick();
    host.r_valid = 1'b1; host.r_rdata = 32'h77; tick(); host.r_valid = 1'b0;
    chk("mr_dvld", sbdata_valid, 1);
    chk("mr_addr", sbaddress_o, 32'h44);
    chk("mr_req_next", host.req, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_req", host.req, 0);
    chk("mr_busy", sbbusy, 0);
    chk("mr_addr0", sbaddress_o, 0);
    chk("mr_data0", sbdata_o, 0);
    chk("mr_add0", host.add, 0);
    chk("mr_be0", host.be, 0);
    chk("mr_dvld0", sbdata_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
